// File: rtl/lift_floor_controller.sv
// Three-floor lift motion/door FSM with latched call requests and a shared down-counter timer.
// Optional emergency stop enabled by defining LIFT_ESTOP_EN (adds estop input and halted output).
module lift_floor_controller #(
  parameter int TRAVEL_CYCLES = 50,
  parameter int DOOR_CYCLES   = 100,
  parameter int TIMER_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
`ifdef LIFT_ESTOP_EN
  input  logic       estop,
  output logic       halted,
`endif
  output logic [2:0] floor_state,
  output logic [1:0] direction,
  output logic       door_open,
  output logic [2:0] pending
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] MOVE_UP   = 2'd1;
  localparam logic [1:0] MOVE_DOWN = 2'd2;
  localparam logic [1:0] DOOR_OPEN = 2'd3;

  localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);

  logic [1:0]         state, state_nxt, state_d;
  logic [TIMER_W-1:0] timer, timer_nxt, timer_d;
  logic [2:0]         floor_nxt, floor_d, clr;
  logic               last_dir, last_dir_nxt, last_dir_d;
  logic               load, freeze;

  function automatic logic above(input logic [2:0] f, input logic [2:0] p);
    return (f[0] & (p[1] | p[2])) | (f[1] & p[2]);
  endfunction

  function automatic logic below(input logic [2:0] f, input logic [2:0] p);
    return (f[2] & (p[1] | p[0])) | (f[1] & p[0]);
  endfunction

  // Idle scheduling rule: serve current floor first, then prefer the last travel direction.
  function automatic logic [1:0] pick(input logic [2:0] f, input logic [2:0] p, input logic ld);
    logic a, b;
    a = above(f, p);
    b = below(f, p);
    if (|(f & p))    return DOOR_OPEN;
    else if (a && b) return ld ? MOVE_UP : MOVE_DOWN;
    else if (a)      return MOVE_UP;
    else if (b)      return MOVE_DOWN;
    return IDLE;
  endfunction

`ifdef LIFT_ESTOP_EN
  assign freeze = estop;
`else
  assign freeze = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    floor_nxt = floor_state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = pick(floor_state, pending, last_dir);
        load      = 1'b1;
      end
      MOVE_UP: begin
        if (timer == '0) begin
          floor_nxt = floor_state[2] ? floor_state : {floor_state[1:0], 1'b0};
          load      = 1'b1;
          if (|(pending & floor_nxt))     state_nxt = DOOR_OPEN;
          else if (above(floor_nxt, pending)) state_nxt = MOVE_UP;
          else                            state_nxt = IDLE;
        end
      end
      MOVE_DOWN: begin
        if (timer == '0) begin
          floor_nxt = floor_state[0] ? floor_state : {1'b0, floor_state[2:1]};
          load      = 1'b1;
          if (|(pending & floor_nxt))     state_nxt = DOOR_OPEN;
          else if (below(floor_nxt, pending)) state_nxt = MOVE_DOWN;
          else                            state_nxt = IDLE;
        end
      end
      default: begin
        // A call for the open floor keeps the door open instead of being latched.
        if (|(req & floor_state)) begin
          state_nxt = DOOR_OPEN;
          load      = 1'b1;
        end else if (timer == '0) begin
          state_nxt = pick(floor_state, pending, last_dir);
          load      = 1'b1;
        end
      end
    endcase

    if (!load)                       timer_nxt = timer - TIMER_W'(1);
    else if (state_nxt == DOOR_OPEN) timer_nxt = DOOR_LOAD;
    else if (state_nxt == IDLE)      timer_nxt = '0;
    else                             timer_nxt = TRAVEL_LOAD;

    if (state_nxt == MOVE_UP)        last_dir_nxt = 1'b1;
    else if (state_nxt == MOVE_DOWN) last_dir_nxt = 1'b0;
    else                             last_dir_nxt = last_dir;

    state_d    = freeze ? state       : state_nxt;
    floor_d    = freeze ? floor_state : floor_nxt;
    timer_d    = freeze ? timer       : timer_nxt;
    last_dir_d = freeze ? last_dir    : last_dir_nxt;
    clr        = (state_d == DOOR_OPEN) ? floor_d : 3'b000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      floor_state <= 3'b001;
      timer       <= '0;
      last_dir    <= 1'b1;
      pending     <= 3'b000;
    end else begin
      state       <= state_d;
      floor_state <= floor_d;
      timer       <= timer_d;
      last_dir    <= last_dir_d;
      pending     <= (pending | req) & ~clr;
    end
  end

`ifdef LIFT_ESTOP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) halted <= 1'b0;
    else     halted <= estop;
  end
`endif

  assign direction = (state == MOVE_UP)   ? 2'b01 :
                     (state == MOVE_DOWN) ? 2'b10 : 2'b00;
  assign door_open = (state == DOOR_OPEN);

endmodule

// File: tb/tb_lift_floor_controller.sv
// Scoreboard bench for lift_floor_controller: stimulus queues cycle-stamped expectations, a monitor checks them.
module tb_lift_floor_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] req = 3'b000;
  logic [2:0] floor_state;
  logic [1:0] direction;
  logic       door_open;
  logic [2:0] pending;
`ifdef LIFT_ESTOP_EN
  logic       estop = 1'b0;
  logic       halted;
`endif

  lift_floor_controller #(.TRAVEL_CYCLES(4), .DOOR_CYCLES(3), .TIMER_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
`ifdef LIFT_ESTOP_EN
    .estop       (estop),
    .halted      (halted),
`endif
    .floor_state (floor_state),
    .direction   (direction),
    .door_open   (door_open),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [8:0] val;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   base = 0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] vec(input logic [2:0] f, input logic [1:0] d,
                                     input logic o, input logic [2:0] p);
    return {f, d, o, p};
  endfunction

  wire [8:0] obs = {floor_state, direction, door_open, pending};

  // Monitor: compares every expectation due at this cycle.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mon_e = sbq.pop_front();
      n_cmp++;
      if (mon_e.cyc != cyc || obs !== mon_e.val) begin
        n_bad++;
        $display("FAIL %s cyc=%0d got=%b required=%b (due cyc %0d)",
                 mon_e.tag, cyc, obs, mon_e.val, mon_e.cyc);
      end
    end
  end

  task automatic seg(input int a, input int b, input logic [8:0] v, input string tag);
    for (int i = a; i <= b; i++) begin
      exp_t e;
      e.cyc = base + i;
      e.val = v;
      e.tag = tag;
      sbq.push_back(e);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [8:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s got=%b required=%b", tag, obs, want);
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (sbq.size() > 0 && k < 200) begin
      step(1);
      k++;
    end
    if (sbq.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout pending_expectations=%0d required=0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    #1 check("reset_initial", vec(3'b001, 2'b00, 1'b0, 3'b000));
    step(2);
    rst = 1'b0;

    // Express trip F0 -> F2 without stopping at F1.
    step(1);
    base = cyc;
    req = 3'b100;
    seg(1, 1,   vec(3'b001, 2'b00, 1'b0, 3'b100), "express_latch");
    seg(2, 5,   vec(3'b001, 2'b01, 1'b0, 3'b100), "express_hop1");
    seg(6, 9,   vec(3'b010, 2'b01, 1'b0, 3'b100), "express_pass_f1");
    seg(10, 12, vec(3'b100, 2'b00, 1'b1, 3'b000), "express_door");
    seg(13, 14, vec(3'b100, 2'b00, 1'b0, 3'b000), "express_idle");
    step(1);
    req = 3'b000;
    wait_done();

    // Down from F2 with a stop at F1.
    base = cyc;
    req = 3'b011;
    seg(1, 1,   vec(3'b100, 2'b00, 1'b0, 3'b011), "down_latch");
    seg(2, 5,   vec(3'b100, 2'b10, 1'b0, 3'b011), "down_hop1");
    seg(6, 8,   vec(3'b010, 2'b00, 1'b1, 3'b001), "down_door_f1");
    seg(9, 12,  vec(3'b010, 2'b10, 1'b0, 3'b001), "down_hop2");
    seg(13, 15, vec(3'b001, 2'b00, 1'b1, 3'b000), "down_door_f0");
    seg(16, 17, vec(3'b001, 2'b00, 1'b0, 3'b000), "down_idle");
    step(1);
    req = 3'b000;
    wait_done();

    // Direction preference: calls both ways at F1 after an upward arrival.
    base = cyc;
    req = 3'b010;
    seg(1, 1,   vec(3'b001, 2'b00, 1'b0, 3'b010), "pref_latch");
    seg(2, 5,   vec(3'b001, 2'b01, 1'b0, 3'b010), "pref_hop_up");
    seg(6, 6,   vec(3'b010, 2'b00, 1'b1, 3'b000), "pref_door_f1");
    seg(7, 8,   vec(3'b010, 2'b00, 1'b1, 3'b101), "pref_dwell_latch");
    seg(9, 12,  vec(3'b010, 2'b01, 1'b0, 3'b101), "pref_go_up");
    seg(13, 15, vec(3'b100, 2'b00, 1'b1, 3'b001), "pref_door_f2");
    seg(16, 19, vec(3'b100, 2'b10, 1'b0, 3'b001), "pref_down1");
    seg(20, 23, vec(3'b010, 2'b10, 1'b0, 3'b001), "pref_pass_f1");
    seg(24, 26, vec(3'b001, 2'b00, 1'b1, 3'b000), "pref_door_f0");
    seg(27, 27, vec(3'b001, 2'b00, 1'b0, 3'b000), "pref_idle");
    step(1);
    req = 3'b000;
    step(5);
    req = 3'b101;
    step(1);
    req = 3'b000;
    wait_done();

    // Door reload: holding the open floor's call keeps the door open.
    base = cyc;
    req = 3'b001;
    seg(1, 1,   vec(3'b001, 2'b00, 1'b0, 3'b001), "reload_latch");
    seg(2, 9,   vec(3'b001, 2'b00, 1'b1, 3'b000), "reload_door");
    seg(10, 11, vec(3'b001, 2'b00, 1'b0, 3'b000), "reload_idle");
    step(1);
    req = 3'b000;
    step(1);
    req = 3'b001;
    step(5);
    req = 3'b000;
    wait_done();

    // Asynchronous reset in the middle of a hop.
    req = 3'b100;
    step(1);
    req = 3'b000;
    step(6);
    check("midop_before_reset", vec(3'b010, 2'b01, 1'b0, 3'b100));
    #2 rst = 1'b1;
    #1 check("midop_reset_async", vec(3'b001, 2'b00, 1'b0, 3'b000));
    step(2);
    rst = 1'b0;
    step(2);
    check("after_reset_idle", vec(3'b001, 2'b00, 1'b0, 3'b000));

`ifdef LIFT_ESTOP_EN
    base = cyc;
    req = 3'b010;
    seg(1, 1,   vec(3'b001, 2'b00, 1'b0, 3'b010), "estop_latch");
    seg(2, 15,  vec(3'b001, 2'b01, 1'b0, 3'b010), "estop_frozen_hop");
    seg(16, 18, vec(3'b010, 2'b00, 1'b1, 3'b000), "estop_arrive");
    seg(19, 19, vec(3'b010, 2'b00, 1'b0, 3'b000), "estop_idle");
    step(1);
    req = 3'b000;
    step(2);
    estop = 1'b1;
    step(5);
    n_cmp++;
    if (halted !== 1'b1) begin
      n_bad++;
      $display("FAIL estop_halted got=%b required=1", halted);
    end
    step(5);
    estop = 1'b0;
    wait_done();
`endif

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lift_floor_controller.md
Name: lift_floor_controller

Overview:
Motion and scheduling FSM for the three-floor lift. It latches hall/cab call requests and steps the car between floors using a travel timer. It holds the door open with a dwell timer. It drives the one-hot floor_state and the 2-bit direction code consumed by the floor/arrow display driver.

Parameters:
TRAVEL_CYCLES, 50, clock cycles per one-floor hop (1 .. 2^TIMER_W-1)
DOOR_CYCLES, 100, clock cycles door stays open (1 .. 2^TIMER_W-1)
TIMER_W, 8, width of the shared down-counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
req  input  3  call request per floor, level, bit0=floor0 ... bit2=floor2
floor_state  output  3  one-hot current floor: 001=F0, 010=F1, 100=F2
direction  output  2  00=stopped, 01=moving up, 10=moving down; 11 never driven
door_open  output  1  high while in DOOR_OPEN
pending  output  3  registered outstanding requests

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values (async, immediate): state=IDLE, floor_state=001, direction=00, door_open=0, pending=000, timer=0, last_dir=up.
- Request latching: pending <= (pending | req) & ~clr every edge. clr = the current-floor bit while in or entering DOOR_OPEN. Latency 1 cycle from req to pending.
- All scheduling decisions use the pending register, never raw req. Exception: the door-reload rule below.
- "above" = any pending bit at a higher floor than the current one; "below" = any pending bit at a lower floor.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- IDLE transitions:
  - pending current-floor bit set -> DOOR_OPEN.
  - else above and below both set -> move in last_dir.
  - else above -> MOVE_UP.
  - else below -> MOVE_DOWN.
  - else stay in IDLE.
- Entering MOVE_x: timer loads TRAVEL_CYCLES-1, last_dir updated, direction = 01 (up) or 10 (down).
- MOVE_x: timer decrements each cycle. On the edge where timer==0, floor_state shifts one floor (up = left shift), so each hop is exactly TRAVEL_CYCLES cycles.
- Arrival evaluation at that same edge, using the new floor:
  - pending bit at new floor -> DOOR_OPEN.
  - else requests further in the same direction -> stay in MOVE_x and reload timer.
  - else -> IDLE.
- Floor saturation: floor_state never shifts beyond 100 or below 001. MOVE_UP is only entered with requests above, and MOVE_DOWN only with requests below.
- DOOR_OPEN:
  - Entry: door_open=1, direction=00, timer=DOOR_CYCLES-1, current-floor pending bit cleared.
  - req for the current floor while in DOOR_OPEN: masked from pending and reloads timer to DOOR_CYCLES-1.
  - Exit at timer==0 with no same-cycle current-floor req. Next state follows the IDLE decision rules, using last_dir preference.
- Simultaneous events:
  - req for a floor being passed mid-hop is latched and serviced on arrival.
  - req for the floor being arrived at on the arrival edge is latched. It is not serviced at this stop unless its pending bit was already set.
- Reset mid-operation: everything returns to reset values at once. Pending requests are discarded.

Optional Feature:
LIFT_ESTOP_EN.
- Defined: adds input estop (1 bit) and output halted (1 bit).
  - While estop=1: timer and state freeze, floor_state and direction hold, halted=1. Requests keep latching.
  - On estop release: operation resumes with the remaining timer count.
  - halted resets to 0.
- Undefined: neither port exists; behaviour is as above.

Test Plan:
All scenarios use TRAVEL_CYCLES=4, DOOR_CYCLES=3.
- Reset: assert rst mid-cycle -> floor_state=001, direction=00, door_open=0, pending=000 immediately, without a clock edge.
- Express trip: at F0/IDLE, pulse req=100 for one cycle.
  - pending=100 next cycle, then direction=01.
  - floor_state=010 after 4 cycles, no stop at F1.
  - floor_state=100 after 8 cycles, door_open=1 for 3 cycles, pending=000, then IDLE with direction=00.
- Down with intermediate stop: at F2, req=011 -> MOVE_DOWN, stop at F1 (door 3 cycles, pending=001), then continue to F0, door, IDLE.
- Direction preference: arrive at F1 moving up, then set req=101 during the door dwell -> next move is up to F2, then down to F0.
- Door reload: at F0 with door open, hold req=001 for 5 cycles -> door_open stays 1 for 5+3 cycles, pending[0] never set.
- LIFT_ESTOP_EN: estop=1 for 10 cycles mid-hop -> floor_state and timer frozen, halted=1. Hop completes exactly the remaining cycles after release.
